// File: rtl/mips_cpu_muldiv.sv
// Iterative multiply/divide unit holding the architectural Hi/Lo registers.
// Radix-2 shift-add multiply and restoring divide, start/busy/done handshake.
module mips_cpu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Multiply: {partial product, multiplier}; divide: low half is dividend/quotient.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opx_q, opx_d;
  logic [WIDTH-1:0]   raw_a_q, raw_a_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dzf_q, dzf_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH-1:0]   rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  always_comb begin
    signed_op = (op == 3'd0) || (op == 3'd2);
    a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opx_q} : '0);
    rem_sh    = {rem_q, acc_q[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, opx_q};
    // Only used when rem_ge, so the result always fits in WIDTH bits.
    rem_sub   = rem_sh[WIDTH-1:0] - opx_q;
    prod_fix  = neg_q ? -acc_q : acc_q;
    quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = rneg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    opx_d      = opx_q;
    raw_a_d    = raw_a_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rneg_d     = rneg_q;
    dzf_d      = dzf_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            3'd0, 3'd1, 3'd2, 3'd3: begin
              div_zero_d = 1'b0;
              is_div_d   = op[1];
              raw_a_d    = a;
              dzf_d      = op[1] && (b == '0);
              neg_d      = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
              rneg_d     = signed_op && a[WIDTH-1];
              rem_d      = '0;
              cnt_d      = CW'(WIDTH);
              state_d    = RUN;
              if (op[1]) begin
                opx_d = b_abs;
                acc_d = {{WIDTH{1'b0}}, a_abs};
              end else begin
                opx_d = a_abs;
                acc_d = {{WIDTH{1'b0}}, b_abs};
              end
            end
            3'd4: begin
              hi_d       = a;
              div_zero_d = 1'b0;
            end
            3'd5: begin
              lo_d       = a;
              div_zero_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (is_div_q) begin
          rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        done_d     = 1'b1;
        state_d    = IDLE;
        div_zero_d = is_div_q && dzf_q;
        if (is_div_q) begin
          if (dzf_q) begin
            hi_d = raw_a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      opx_q      <= '0;
      raw_a_q    <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      dzf_q      <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      opx_q      <= opx_d;
      raw_a_q    <= raw_a_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rneg_q     <= rneg_d;
      dzf_q      <= dzf_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Bench for mips_cpu_muldiv: vector table plus scoreboard at WIDTH=32,
// reset/MTHI/MTLO corner sequences, and a WIDTH=16 divide.
module tb_mips_cpu_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start16;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, done16, div_zero16;
  logic [15:0] hi16, lo16;

  always #5 clk = ~clk;

  mips_cpu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mips_cpu_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .div_zero(div_zero16), .hi(hi16), .lo(lo16)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[11];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(xa);
    sb = $signed(xb);
    e.dz = 1'b0;
    case (o)
      3'd0: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd1: begin p = {32'b0, xa} * {32'b0, xb}; e.hi = p[63:32]; e.lo = p[31:0]; end
      3'd2: begin
        if (xb == 32'd0) begin e.hi = xa; e.lo = '1; e.dz = 1'b1; end
        else begin q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0]; end
      end
      default: begin
        if (xb == 32'd0) begin e.hi = xa; e.lo = '1; e.dz = 1'b1; end
        else begin e.lo = xa / xb; e.hi = xa % xb; end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge with the unit idle (or in its done cycle); returns at the
  // negedge of the done cycle so the next call issues back-to-back.
  task automatic do_op(input logic [2:0] o, input logic [31:0] xa, input logic [31:0] xb,
                       input exp_t e, input int inject, input string nm);
    logic [31:0] hi0, lo0;
    int          cyc;
    bit          held;
    exp_t        got;
    hi0 = hi; lo0 = lo; held = 1'b1;
    start = 1'b1; op = o; a = xa; b = xb;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    chk({nm, "_busy_accept"}, busy, 1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (hi !== hi0 || lo !== lo0 || !busy) held = 1'b0;
      if (cyc == inject) begin
        start = 1'b1; op = 3'd5; a = 32'hDEADBEEF;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, cyc, 33);
    chk({nm, "_hold_busy"}, held, 1);
    chk({nm, "_busy_done"}, busy, 0);
    if (sb_q.size() == 0) begin
      chk({nm, "_sb_empty"}, 1, 0);
    end else begin
      got = sb_q.pop_front();
      chk({nm, "_hi"}, hi, got.hi);
      chk({nm, "_lo"}, lo, got.lo);
      chk({nm, "_dz"}, div_zero, got.dz);
    end
  endtask

  initial begin
    int   cyc;
    bit   saw_done;
    exp_t e;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    tbl[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    tbl[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    tbl[3]  = '{3'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    tbl[5]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    tbl[6]  = '{3'd1, 32'd7,        32'd6,        32'h00000000, 32'd42,       1'b0};
    tbl[7]  = '{3'd2, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
    tbl[8]  = '{3'd3, 32'h12345678, 32'h100,      32'h00000078, 32'h00123456, 1'b0};
    tbl[9]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    tbl[10] = '{3'd0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst16_hilo", {hi16, lo16}, 0);
    chk("rst16_busy", busy16, 0);

    for (int i = 0; i < 11; i++) begin
      e.hi = tbl[i].hi; e.lo = tbl[i].lo; e.dz = tbl[i].dz;
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, e, (i == 4) ? 5 : -1, $sformatf("vec%0d", i));
      if (i == 3) begin
        // MTHI issued in the done cycle of a divide-by-zero.
        start = 1'b1; op = 3'd4; a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, 32'hFFFFFFFF);
        chk("mthi_dz", div_zero, 0);
        chk("mthi_busy", busy, 0);
        chk("mthi_done", done, 0);
        start = 1'b1; op = 3'd5; a = 32'h5678;
        @(negedge clk);
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h5678);
        chk("mtlo_hi", hi, 32'h1234);
        start = 1'b1; op = 3'd6; a = 32'hAAAA5555; b = 32'h1;
        @(negedge clk);
        start = 1'b0;
        chk("op6_hilo", {hi, lo}, {32'h1234, 32'h5678});
        chk("op6_busy", busy, 0);
      end
    end

    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 0) ? 32'd0 : $urandom;
      if (i == 1) rb = 32'd3;
      do_op(ro, ra, rb, model(ro, ra, rb), -1, $sformatf("rnd%0d", i));
    end

    // Reset ten cycles after acceptance aborts the divide.
    start = 1'b1; op = 3'd3; a = 32'h12345678; b = 32'h100;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hilo", {hi, lo}, 0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", saw_done, 0);
    e.hi = 32'd0; e.lo = 32'd42; e.dz = 1'b0;
    do_op(3'd1, 32'd7, 32'd6, e, -1, "post_abort_multu");

    // WIDTH=16 signed divide.
    start16 = 1'b1; op16 = 3'd2; a16 = 16'hFFF9; b16 = 16'd2;
    @(negedge clk);
    start16 = 1'b0; a16 = 16'h1111; b16 = 16'h0;
    cyc = 0;
    while (!done16 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("w16_latency", cyc, 17);
    chk("w16_lo", lo16, 16'hFFFD);
    chk("w16_hi", hi16, 16'hFFFF);
    chk("w16_dz", div_zero16, 0);
    chk("w16_busy", busy16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
